fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
- Sequences the core's program counter and the instruction-memory fetch port.
- Holds the PC register, issues one outstanding fetch request at a time with a req/grant plus response-valid handshake, and hands fetched instructions to decode with valid/ready.
- Applies branch and trap redirects, squashing wrong-path fetches.

Parameters:
ADDR_W, 8, width of PC and fetch address
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
TRAP_VEC, 8'h80, redirect target on trap (word aligned)

Ports:
iCLK  in  1  clock, rising edge
iRST_N  in  1  asynchronous reset, active low
iBR_ENABLE  in  1  branch/jump redirect strobe
iBR_ADDR  in  ADDR_W  branch target
iTRAP  in  1  trap redirect strobe
iHALT  in  1  suppress new fetch requests
oIMEM_REQ  out  1  fetch request
oIMEM_ADDR  out  ADDR_W  fetch address
iIMEM_GNT  in  1  request accepted this cycle
iIMEM_RVALID  in  1  response valid
iIMEM_RDATA  in  INSTR_W  response data
oINSTR_VALID  out  1  instruction to decode valid
oINSTR  out  INSTR_W  fetched instruction
oINSTR_PC  out  ADDR_W  address of oINSTR
iINSTR_READY  in  1  decode accepts instruction
oPC  out  ADDR_W  current PC register (next address to fetch)

Behaviour:
- Reset (iRST_N=0, async):
  - State IDLE; PC=RESET_PC.
  - oIMEM_REQ=0, oINSTR_VALID=0, oINSTR=0, oINSTR_PC=0, kill flag cleared.
- States: IDLE, REQ, WAIT, HOLD, DRAIN. All outputs are registered except oIMEM_REQ/oIMEM_ADDR, which decode from the state and PC.
- IDLE:
  - iHALT=0 -> REQ on the next edge.
  - iIMEM_RVALID is ignored (covers a stale response after reset).
- REQ:
  - oIMEM_REQ=1, oIMEM_ADDR=PC. Memory samples the address only on iIMEM_GNT.
  - GNT -> latch fetch_pc=PC; PC<=PC+4 (mod 2^ADDR_W, wraps to 0); go to WAIT.
- WAIT: on iIMEM_RVALID -> oINSTR<=RDATA, oINSTR_PC<=fetch_pc, oINSTR_VALID<=1, go to HOLD. Minimum latency from reset release to first oINSTR_VALID is 3 cycles with GNT and RVALID each one cycle after entry.
- HOLD:
  - oINSTR_VALID, oINSTR and oINSTR_PC stay stable until iINSTR_READY=1.
  - On acceptance, oINSTR_VALID drops; go to REQ, or to IDLE if iHALT=1.
- DRAIN: wait for iIMEM_RVALID, discard the data, then go to REQ (IDLE if iHALT=1).
- Redirect:
  - Active when iTRAP or iBR_ENABLE is set. iTRAP has priority.
  - Target is TRAP_VEC for a trap, otherwise iBR_ADDR with bits [1:0] forced to 0.
  - PC<=target in every state. Fetch_pc is not updated.
- Redirect per state:
  - IDLE: PC updated only.
  - REQ without GNT: PC updated; the request address switches next cycle.
  - REQ with GNT in the same cycle: the issued fetch is wrong-path; go to DRAIN.
  - WAIT without RVALID: go to DRAIN.
  - WAIT with RVALID in the same cycle: data dropped, oINSTR_VALID stays 0; go to REQ.
  - HOLD: oINSTR_VALID<=0 next cycle, even if iINSTR_READY=1 in the same cycle (redirect wins); go to REQ.
  - DRAIN: PC updated; remain in DRAIN.
- Halt:
  - iHALT=1 in REQ with no GNT withdraws the request (go to IDLE).
  - iHALT does not affect WAIT, HOLD or DRAIN.
  - Releasing iHALT in IDLE gives REQ on the next cycle.
- Never more than one outstanding request. GNT outside REQ and RVALID outside WAIT/DRAIN are ignored.

Test Plan:
- Reset release, GNT and RVALID each one cycle after request, READY=1 -> fetch addresses 0x00, 0x04, 0x08; oINSTR_PC matches; first oINSTR_VALID on the 3rd cycle after release.
- iINSTR_READY held 0 for 5 cycles in HOLD -> oINSTR/oINSTR_PC stable, oIMEM_REQ=0, no new GNT consumed; PC stays at fetch_pc+4.
- iBR_ENABLE with iBR_ADDR=0x43 in WAIT -> DRAIN; the RVALID data is never presented; next oIMEM_ADDR=0x40.
- iTRAP and iBR_ENABLE (0x20) asserted together in HOLD with READY=1 -> oINSTR_VALID=0 next cycle; next oIMEM_ADDR=0x80.
- PC=0xFC fetched -> next oIMEM_ADDR=0x00 (wrap).
- iRST_N pulsed low during WAIT, then RVALID arrives -> outputs at reset values, response ignored, next fetch at RESET_PC. iHALT in REQ without GNT -> oIMEM_REQ=0 next cycle.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, keeps one imem request in flight, hands instructions to decode.
// First instruction 3 cycles after reset; holds the instruction until iINSTR_READY, never issues while holding.
module fetch_controller #(
   parameter int                  ADDR_W   = 8,
   parameter int                  INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]   RESET_PC = '0,
   parameter logic [ADDR_W-1:0]   TRAP_VEC = 8'h80
) (
   input  logic                iCLK,
   input  logic                iRST_N,
   input  logic                iBR_ENABLE,
   input  logic [ADDR_W-1:0]   iBR_ADDR,
   input  logic                iTRAP,
   input  logic                iHALT,
   output logic                oIMEM_REQ,
   output logic [ADDR_W-1:0]   oIMEM_ADDR,
   input  logic                iIMEM_GNT,
   input  logic                iIMEM_RVALID,
   input  logic [INSTR_W-1:0]  iIMEM_RDATA,
   output logic                oINSTR_VALID,
   output logic [INSTR_W-1:0]  oINSTR,
   output logic [ADDR_W-1:0]   oINSTR_PC,
   input  logic                iINSTR_READY,
   output logic [ADDR_W-1:0]   oPC
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   fetchPc;
   logic                redirect;
   logic [ADDR_W-1:0]   redirTarget;

   assign redirect    = iTRAP | iBR_ENABLE;
   assign redirTarget = iTRAP ? TRAP_VEC : (iBR_ADDR & ~ADDR_W'(3));

   assign oIMEM_REQ  = (state == REQ);
   assign oIMEM_ADDR = pc;
   assign oPC        = pc;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         fetchPc      <= RESET_PC;
         oINSTR_VALID <= 1'b0;
         oINSTR       <= '0;
         oINSTR_PC    <= '0;
      end else begin
         if (redirect) begin
            pc <= redirTarget;
         end
         case (state)
            IDLE: begin
               if (!iHALT) state <= REQ;
            end
            REQ: begin
               if (iIMEM_GNT) begin
                  // A grant coinciding with a redirect is already wrong-path; drain it.
                  if (redirect) begin
                     state <= DRAIN;
                  end else begin
                     fetchPc <= pc;
                     pc      <= pc + ADDR_W'(4);
                     state   <= WAIT;
                  end
               end else if (iHALT) begin
                  state <= IDLE;
               end
            end
            WAIT: begin
               if (iIMEM_RVALID) begin
                  if (redirect) begin
                     state <= REQ;
                  end else begin
                     oINSTR       <= iIMEM_RDATA;
                     oINSTR_PC    <= fetchPc;
                     oINSTR_VALID <= 1'b1;
                     state        <= HOLD;
                  end
               end else if (redirect) begin
                  state <= DRAIN;
               end
            end
            HOLD: begin
               if (redirect) begin
                  oINSTR_VALID <= 1'b0;
                  state        <= REQ;
               end else if (iINSTR_READY) begin
                  oINSTR_VALID <= 1'b0;
                  state        <= iHALT ? IDLE : REQ;
               end
            end
            DRAIN: begin
               if (iIMEM_RVALID) state <= iHALT ? IDLE : REQ;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
